// File: rtl/time_manager_pkg.sv
// Shared definitions for the time-management blocks: measurement FSM encoding
// and default widths used by clock_period_meter.
package time_manager_pkg;

   localparam int CNT_W_DEF       = 16;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_MEAS_HIGH = 3'd2,
      ST_MEAS_LOW  = 3'd3,
      ST_DONE      = 3'd4
   } meas_state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Brings an asynchronous level into the CLK_IN domain and derives single-cycle
// rise/fall strobes from the synchronized level and its previous value.
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK_IN,
   input  logic RST,
   input  logic sig_in,
   output logic sync_level,
   output logic rise_det,
   output logic fall_det
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Both strobes come from the same two registers, so rise and fall latency match.
   assign sync_level = sync_q[SYNC_STAGES-1];
   assign rise_det   = sync_level & ~prev_q;
   assign fall_det   = ~sync_level & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Single-shot period / high-time meter for a slow signal, counted in CLK_IN
// cycles with saturating counters and an overflow flag.
module clock_period_meter
   import time_manager_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             SIG_IN,
   input  logic             START,
   output logic             BUSY,
   output logic             VALID,
   output logic [CNT_W-1:0] PERIOD_OUT,
   output logic [CNT_W-1:0] HIGH_OUT,
   output logic             OVF,
   output logic [2:0]       STATE_DBG,
   output logic             SIG_SYNC
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   meas_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] high_cnt;
   logic             rise_det;
   logic             fall_det;

   sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK_IN     (CLK_IN),
      .RST        (RST),
      .sig_in     (SIG_IN),
      .sync_level (SIG_SYNC),
      .rise_det   (rise_det),
      .fall_det   (fall_det)
   );

   // A fall exactly at the limit must not wrap the count entering MEAS_LOW.
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   assign STATE_DBG = state;

   // Handshake: START is a one-cycle request honoured only in IDLE; BUSY rises
   // the cycle after it is taken and falls in the single cycle VALID is high,
   // which is also the only cycle PERIOD_OUT, HIGH_OUT and OVF change.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         high_cnt   <= '0;
         BUSY       <= 1'b0;
         VALID      <= 1'b0;
         PERIOD_OUT <= '0;
         HIGH_OUT   <= '0;
         OVF        <= 1'b0;
      end else begin
         VALID <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (START) begin
                  state <= ST_ARM;
                  BUSY  <= 1'b1;
               end
            end
            ST_ARM: begin
               if (rise_det) begin
                  state <= ST_MEAS_HIGH;
                  cnt   <= CNT_ONE;
               end
            end
            ST_MEAS_HIGH: begin
               if (fall_det) begin
                  high_cnt <= cnt;
                  cnt      <= cnt_inc;
                  state    <= ST_MEAS_LOW;
               end else if (cnt == CNT_MAX) begin
                  PERIOD_OUT <= CNT_MAX;
                  HIGH_OUT   <= CNT_MAX;
                  OVF        <= 1'b1;
                  VALID      <= 1'b1;
                  BUSY       <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_MEAS_LOW: begin
               if (rise_det) begin
                  PERIOD_OUT <= cnt;
                  HIGH_OUT   <= high_cnt;
                  OVF        <= 1'b0;
                  VALID      <= 1'b1;
                  BUSY       <= 1'b0;
                  state      <= ST_DONE;
               end else if (cnt == CNT_MAX) begin
                  PERIOD_OUT <= CNT_MAX;
                  HIGH_OUT   <= high_cnt;
                  OVF        <= 1'b1;
                  VALID      <= 1'b1;
                  BUSY       <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
